// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 serial receiver for the TDC capture loopback/host path.
// Recovers bytes from the RX line, presents them on D with a one-cycle RDY
// strobe, and flags a low stop bit with a one-cycle FERR strobe.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    output logic [7:0] D,
    output logic       RDY,
    output logic       FERR,
    output logic       BUSY
);

    localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
    // The synchronizer holds its reset value for two clocks after reset is
    // released, so WAIT_HIGH ignores rx_s until real line data has arrived.
    localparam logic [15:0] SETTLE    = 16'd2;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  sh, sh_n;
    logic [7:0]  d_n;
    logic        rdy_n, ferr_n;

    // Two-flop synchronizer bringing the asynchronous line into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX;
            rx_s <= rx_m;
        end
    end

    // State, counters, shift register and output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_HIGH;
            cnt   <= 16'd0;
            idx   <= 3'd0;
            sh    <= 8'h00;
            D     <= 8'h00;
            RDY   <= 1'b0;
            FERR  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            D     <= d_n;
            RDY   <= rdy_n;
            FERR  <= ferr_n;
        end
    end

    // Next-state logic: bit timing, start validation, data shifting, stop check.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        d_n     = D;
        rdy_n   = 1'b0;
        ferr_n  = 1'b0;

        case (state)
            WAIT_HIGH: begin
                if (cnt != SETTLE) begin
                    cnt_n = cnt + 16'd1;
                end else if (rx_s) begin
                    state_n = IDLE;
                    cnt_n   = 16'd0;
                end
            end

            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = 16'd0;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = 16'd0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = 16'd0;
                    sh_n  = {rx_s, sh[7:1]};
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = 16'd0;
                    if (rx_s) begin
                        d_n     = sh;
                        rdy_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            default: begin
                state_n = WAIT_HIGH;
                cnt_n   = 16'd0;
            end
        endcase
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: self-checking bench for rs232_rx at 16 clocks per bit.
module tb_rs232_rx;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic [7:0] D;
    logic       RDY, FERR, BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_high = 0;
    logic [7:0] last_d = 8'h00;

    int         rdy_cyc[$];
    logic [7:0] rdy_d[$];
    int         ferr_cyc[$];

    rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .RX(RX),
        .D(D), .RDY(RDY), .FERR(FERR), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe cycle so tests can compare against expected timing.
    always @(negedge clk) begin
        if (RDY) begin
            rdy_cyc.push_back(cyc);
            rdy_d.push_back(D);
        end
        if (FERR) ferr_cyc.push_back(cyc);
        if (RDY && FERR) both_high++;
    end

    task automatic clear_log();
        rdy_cyc.delete();
        rdy_d.delete();
        ferr_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame; e is the edge that first samples the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e);
        RX = 1'b0;
        e = cyc + 1;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            idle(CPB);
        end
        RX = stop_bit;
        idle(CPB);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RX = 1'b1;
        idle(3);
        checks++;
        if (D !== 8'h00) begin errors++; $display("[TB] FAIL reset_D got %0h expected 00", D); end
        checks++;
        if (RDY !== 1'b0 || FERR !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_strobes got RDY=%0b FERR=%0b expected 0 0", RDY, FERR);
        end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL reset_BUSY got %0b expected 1", BUSY); end
        reset = 1'b0;
        idle(6);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL idle_BUSY got %0b expected 0", BUSY); end
        last_d = 8'h00;
    endtask

    task automatic test_single();
        int e;
        clear_log();
        send_frame(8'hA5, 1'b1, e);
        idle(10);
        checks++;
        if (rdy_cyc.size() !== 1) begin
            errors++; $display("[TB] FAIL single_rdy_count got %0d expected 1", rdy_cyc.size());
        end else begin
            checks++;
            if (rdy_cyc[0] !== e + LAT) begin
                errors++; $display("[TB] FAIL single_latency got %0d expected %0d", rdy_cyc[0], e + LAT);
            end
            checks++;
            if (rdy_d[0] !== 8'hA5) begin errors++; $display("[TB] FAIL single_data got %0h expected a5", rdy_d[0]); end
        end
        checks++;
        if (ferr_cyc.size() !== 0) begin errors++; $display("[TB] FAIL single_ferr got %0d expected 0", ferr_cyc.size()); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL single_BUSY got %0b expected 0", BUSY); end
        last_d = 8'hA5;
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        clear_log();
        send_frame(8'h00, 1'b1, e0);
        send_frame(8'hFF, 1'b1, e1);
        idle(10);
        checks++;
        if (rdy_cyc.size() !== 2) begin
            errors++; $display("[TB] FAIL b2b_rdy_count got %0d expected 2", rdy_cyc.size());
        end else begin
            checks++;
            if (rdy_cyc[1] - rdy_cyc[0] !== 10 * CPB) begin
                errors++; $display("[TB] FAIL b2b_spacing got %0d expected %0d", rdy_cyc[1] - rdy_cyc[0], 10 * CPB);
            end
            checks++;
            if (rdy_d[0] !== 8'h00 || rdy_d[1] !== 8'hFF) begin
                errors++; $display("[TB] FAIL b2b_data got %0h %0h expected 00 ff", rdy_d[0], rdy_d[1]);
            end
            checks++;
            if (rdy_cyc[0] !== e0 + LAT) begin
                errors++; $display("[TB] FAIL b2b_latency got %0d expected %0d", rdy_cyc[0], e0 + LAT);
            end
        end
        last_d = 8'hFF;
    endtask

    task automatic test_glitch();
        clear_log();
        RX = 1'b0;
        idle(4);
        RX = 1'b1;
        idle(40);
        checks++;
        if (rdy_cyc.size() !== 0 || ferr_cyc.size() !== 0) begin
            errors++; $display("[TB] FAIL glitch_strobes got %0d %0d expected 0 0", rdy_cyc.size(), ferr_cyc.size());
        end
        checks++;
        if (D !== last_d) begin errors++; $display("[TB] FAIL glitch_D got %0h expected %0h", D, last_d); end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL glitch_BUSY got %0b expected 0", BUSY); end
    endtask

    task automatic test_framing();
        int e;
        clear_log();
        send_frame(8'h3C, 1'b0, e);
        idle(40);
        checks++;
        if (ferr_cyc.size() !== 1) begin
            errors++; $display("[TB] FAIL ferr_count got %0d expected 1", ferr_cyc.size());
        end else begin
            checks++;
            if (ferr_cyc[0] !== e + LAT) begin
                errors++; $display("[TB] FAIL ferr_time got %0d expected %0d", ferr_cyc[0], e + LAT);
            end
        end
        checks++;
        if (rdy_cyc.size() !== 0) begin errors++; $display("[TB] FAIL ferr_rdy got %0d expected 0", rdy_cyc.size()); end
        checks++;
        if (D !== last_d) begin errors++; $display("[TB] FAIL ferr_D got %0h expected %0h", D, last_d); end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL ferr_BUSY_low_line got %0b expected 1", BUSY); end
        RX = 1'b1;
        idle(10);
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL ferr_BUSY_recover got %0b expected 0", BUSY); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int e;
        b = 8'hC3;
        clear_log();
        RX = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            RX = b[i];
            idle(CPB);
        end
        RX = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(12 * CPB);
        checks++;
        if (rdy_cyc.size() !== 0 || ferr_cyc.size() !== 0) begin
            errors++; $display("[TB] FAIL midreset_strobes got %0d %0d expected 0 0", rdy_cyc.size(), ferr_cyc.size());
        end
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("[TB] FAIL midreset_BUSY got %0b expected 1", BUSY); end
        checks++;
        if (D !== 8'h00) begin errors++; $display("[TB] FAIL midreset_D got %0h expected 00", D); end
        last_d = 8'h00;
        RX = 1'b1;
        idle(20);
        send_frame(8'h5A, 1'b1, e);
        idle(10);
        checks++;
        if (rdy_cyc.size() !== 1) begin
            errors++; $display("[TB] FAIL midreset_next_count got %0d expected 1", rdy_cyc.size());
        end else begin
            checks++;
            if (rdy_d[0] !== 8'h5A || rdy_cyc[0] !== e + LAT) begin
                errors++; $display("[TB] FAIL midreset_next got %0h@%0d expected 5a@%0d", rdy_d[0], rdy_cyc[0], e + LAT);
            end
        end
        last_d = 8'h5A;
    endtask

    task automatic test_loopback();
        int e, eot;
        clear_log();
        send_frame(8'h7E, 1'b1, e);
        eot = cyc;
        idle(2 * CPB + 2);
        checks++;
        if (rdy_cyc.size() !== 1) begin
            errors++; $display("[TB] FAIL loop_count got %0d expected 1", rdy_cyc.size());
        end else begin
            checks++;
            if (rdy_d[0] !== 8'h7E) begin errors++; $display("[TB] FAIL loop_data got %0h expected 7e", rdy_d[0]); end
            checks++;
            if (rdy_cyc[0] > eot + 2 * CPB) begin
                errors++; $display("[TB] FAIL loop_deadline got %0d expected <= %0d", rdy_cyc[0], eot + 2 * CPB);
            end
        end
        last_d = 8'h7E;
    endtask

    task automatic test_random();
        int         exp_rdy_cyc[$];
        logic [7:0] exp_rdy_d[$];
        int         exp_ferr_cyc[$];
        logic [7:0] b;
        logic       good;
        int         e, gap;
        clear_log();
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good, e);
            if (good) begin
                exp_rdy_cyc.push_back(e + LAT);
                exp_rdy_d.push_back(b);
                last_d = b;
                gap = $urandom_range(0, 20);
            end else begin
                exp_ferr_cyc.push_back(e + LAT);
                gap = $urandom_range(4, 20);
            end
            RX = 1'b1;
            idle(gap);
        end
        idle(20);
        checks++;
        if (rdy_cyc.size() !== exp_rdy_cyc.size()) begin
            errors++; $display("[TB] FAIL rand_rdy_count got %0d expected %0d", rdy_cyc.size(), exp_rdy_cyc.size());
        end else begin
            for (int i = 0; i < exp_rdy_cyc.size(); i++) begin
                checks++;
                if (rdy_cyc[i] !== exp_rdy_cyc[i] || rdy_d[i] !== exp_rdy_d[i]) begin
                    errors++;
                    $display("[TB] FAIL rand_frame%0d got %0h@%0d expected %0h@%0d",
                             i, rdy_d[i], rdy_cyc[i], exp_rdy_d[i], exp_rdy_cyc[i]);
                end
            end
        end
        checks++;
        if (ferr_cyc.size() !== exp_ferr_cyc.size()) begin
            errors++; $display("[TB] FAIL rand_ferr_count got %0d expected %0d", ferr_cyc.size(), exp_ferr_cyc.size());
        end else begin
            for (int i = 0; i < exp_ferr_cyc.size(); i++) begin
                checks++;
                if (ferr_cyc[i] !== exp_ferr_cyc[i]) begin
                    errors++; $display("[TB] FAIL rand_ferr%0d got %0d expected %0d", i, ferr_cyc[i], exp_ferr_cyc[i]);
                end
            end
        end
        checks++;
        if (D !== last_d) begin errors++; $display("[TB] FAIL rand_final_D got %0h expected %0h", D, last_d); end
        checks++;
        if (both_high !== 0) begin errors++; $display("[TB] FAIL rdy_ferr_overlap got %0d expected 0", both_high); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_loopback();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
